operand_axis_split: RTL and testbench

OPERAND_AXIS_SPLIT -- requirements
Module: operand_axis_split

---
 rtl/operand_axis_split.sv | 118 +++++++++++
 tb/tb_operand_axis_split.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/operand_axis_split.sv
// Splits a packed operand pair into two independently buffered AXI-Stream outputs.
// Both FIFOs are written on the same edge, so output beats stay paired by position.
module operand_axis_split_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic         o_full,
  output logic [W-1:0] o_data
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign w_pop   = (r_count != '0) & i_ready;
  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == FULL);
  assign o_data  = r_mem[r_rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module operand_axis_split #(
  parameter int ADDER_WIDTH    = 4,
  parameter int OUT_AXIS_WIDTH = 8,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                        ACLK_I,
  input  logic                        ARST_N,
  input  logic [2*OUT_AXIS_WIDTH-1:0] data_i_tdata,
  input  logic                        data_i_tvalid,
  output logic                        data_i_tready,
  output logic [OUT_AXIS_WIDTH-1:0]   data1_o_tdata,
  output logic                        data1_o_tvalid,
  input  logic                        data1_o_tready,
  output logic [OUT_AXIS_WIDTH-1:0]   data2_o_tdata,
  output logic                        data2_o_tvalid,
  input  logic                        data2_o_tready
);
  logic [OUT_AXIS_WIDTH-1:0] w_op1;
  logic [OUT_AXIS_WIDTH-1:0] w_op2;
  logic                      w_push;
  logic                      w_full1;
  logic                      w_full2;
  logic                      w_unused;

  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    w_op1[ADDER_WIDTH-1:0] = data_i_tdata[ADDER_WIDTH-1:0];
    w_op2[ADDER_WIDTH-1:0] = data_i_tdata[OUT_AXIS_WIDTH +: ADDER_WIDTH];
  end

  assign w_unused = ^data_i_tdata;

  // Ready depends only on registered fill levels, never on output readies.
  assign data_i_tready = ~w_full1 & ~w_full2;
  assign w_push        = data_i_tvalid & data_i_tready;

  operand_axis_split_fifo #(
    .W     (OUT_AXIS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk     (ACLK_I),
    .rst_n   (ARST_N),
    .i_push  (w_push),
    .i_data  (w_op1),
    .i_ready (data1_o_tready),
    .o_valid (data1_o_tvalid),
    .o_full  (w_full1),
    .o_data  (data1_o_tdata)
  );

  operand_axis_split_fifo #(
    .W     (OUT_AXIS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo2 (
    .clk     (ACLK_I),
    .rst_n   (ARST_N),
    .i_push  (w_push),
    .i_data  (w_op2),
    .i_ready (data2_o_tready),
    .o_valid (data2_o_tvalid),
    .o_full  (w_full2),
    .o_data  (data2_o_tdata)
  );
endmodule

// File: tb/tb_operand_axis_split.sv
// Directed and randomized checks of operand_axis_split against a queue model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_operand_axis_split;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        vin;
  logic        in_rdy;
  logic [7:0]  d1;
  logic        v1;
  logic        r1;
  logic [7:0]  d2;
  logic        v2;
  logic        r2;

  int n_tests;
  int n_fail;
  int n_out1;
  int n_out2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  operand_axis_split #(
    .ADDER_WIDTH    (4),
    .OUT_AXIS_WIDTH (8),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .ACLK_I         (clk),
    .ARST_N         (rst_n),
    .data_i_tdata   (din),
    .data_i_tvalid  (vin),
    .data_i_tready  (in_rdy),
    .data1_o_tdata  (d1),
    .data1_o_tvalid (v1),
    .data1_o_tready (r1),
    .data2_o_tdata  (d2),
    .data2_o_tvalid (v2),
    .data2_o_tready (r2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [15:0] d, input logic v,
                      input logic rr1, input logic rr2);
    logic e_rdy;
    @(negedge clk);
    din = d;
    vin = v;
    r1  = rr1;
    r2  = rr2;
    #1;
    e_rdy = (q1.size() < DEPTH) && (q2.size() < DEPTH);
    chk("in_rdy", {31'd0, in_rdy}, {31'd0, e_rdy});
    chk("v1", {31'd0, v1}, {31'd0, q1.size() != 0});
    chk("v2", {31'd0, v2}, {31'd0, q2.size() != 0});
    if (q1.size() != 0) chk("d1", {24'd0, d1}, {24'd0, q1[0]});
    if (q2.size() != 0) chk("d2", {24'd0, d2}, {24'd0, q2[0]});
    if (q1.size() != 0 && rr1) begin
      void'(q1.pop_front());
      n_out1++;
    end
    if (q2.size() != 0 && rr2) begin
      void'(q2.pop_front());
      n_out2++;
    end
    if (v && e_rdy) begin
      q1.push_back({4'h0, d[3:0]});
      q2.push_back({4'h0, d[11:8]});
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_out1  = 0;
    n_out2  = 0;
    rst_n   = 1'b0;
    din     = '0;
    vin     = 1'b0;
    r1      = 1'b1;
    r2      = 1'b1;
    #3;
    chk("rst_v1", {31'd0, v1}, 32'd0);
    chk("rst_v2", {31'd0, v2}, 32'd0);
    chk("rst_d1", {24'd0, d1}, 32'd0);
    chk("rst_d2", {24'd0, d2}, 32'd0);
    #5;
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", {31'd0, in_rdy}, 32'd1);

    // Single beat, accepted on the first edge after release
    step(16'h0A05, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("one_d1", {24'd0, d1}, 32'h05);
    chk("one_d2", {24'd0, d2}, 32'h0A);
    chk("one_v1", {31'd0, v1}, 32'd1);
    step(16'h0000, 1'b0, 1'b1, 1'b1);
    step(16'h0000, 1'b0, 1'b1, 1'b1);

    // Masking of upper bits in each half
    step(16'hFFFF, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("mask_d1", {24'd0, d1}, 32'h0F);
    chk("mask_d2", {24'd0, d2}, 32'h0F);
    step(16'h0000, 1'b0, 1'b1, 1'b1);
    step(16'h0000, 1'b0, 1'b1, 1'b1);

    // Back-to-back streaming
    n_out1 = 0;
    n_out2 = 0;
    for (int i = 0; i < 100; i++)
      step(16'($urandom), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step(16'h0000, 1'b0, 1'b1, 1'b1);
    chk("stream_n1", n_out1, 32'd100);
    chk("stream_n2", n_out2, 32'd100);

    // Skew: output 2 stalled until its FIFO fills and blocks input
    step(16'h0201, 1'b1, 1'b1, 1'b0);
    step(16'h0403, 1'b1, 1'b1, 1'b0);
    step(16'h0605, 1'b1, 1'b1, 1'b0);
    step(16'h0605, 1'b1, 1'b1, 1'b0);
    chk("skew_blk", {31'd0, in_rdy}, 32'd0);
    chk("skew_d2", {24'd0, d2}, 32'h02);
    step(16'h0605, 1'b1, 1'b1, 1'b1);
    step(16'h0605, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      step(16'h0000, 1'b0, 1'b1, 1'b1);

    // Reset while two beats are buffered
    step(16'h0807, 1'b1, 1'b0, 1'b0);
    step(16'h0A09, 1'b1, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_v1", {31'd0, v1}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v1", {31'd0, v1}, 32'd0);
    chk("mid_rst_v2", {31'd0, v2}, 32'd0);
    q1.delete();
    q2.delete();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step(16'h0000, 1'b0, 1'b1, 1'b1);

    // Random traffic and backpressure
    for (int i = 0; i < 10000; i++)
      step(16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++)
      step(16'h0000, 1'b0, 1'b1, 1'b1);
    chk("rand_q1", q1.size(), 32'd0);
    chk("rand_q2", q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
